// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared states, increment and default vectors for the PC sequencer
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2
  } pc_state_e;

  localparam logic [31:0] PC_INC        = 32'd4;
  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0100;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - instruction-memory request/grant bus
interface pc_sequencer_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt
  );

endinterface

// File: rtl/pc_next_mux.sv
// rtl/pc_next_mux.sv - priority next-PC select (trap > jump > branch > hold > +4)
// Trap path is active only when PC_SEQ_MISALIGN_TRAP_EN is defined.
module pc_next_mux
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] TRAP_VEC = DEF_TRAP_VEC
) (
  input  logic        active_i,
  input  logic        xfer_i,
  input  logic        stall_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  input  logic        jmp_i,
  input  logic [31:0] jmp_target_i,
  input  logic [31:0] pc_i,
  output logic [31:0] pc_nxt_o,
  output logic        redirect_o,
  output logic        misalign_o
);

  logic [31:0] target;

  always_comb begin
    target     = jmp_i ? jmp_target_i : br_target_i;
    redirect_o = active_i & (jmp_i | br_taken_i);
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    misalign_o = redirect_o & is_misaligned(target);
`else
    misalign_o = 1'b0;
`endif
    pc_nxt_o = pc_i;
    if (misalign_o) begin
      pc_nxt_o = TRAP_VEC;
    end else if (redirect_o) begin
      pc_nxt_o = target;
    end else if (stall_i || !xfer_i) begin
      pc_nxt_o = pc_i;
    end else begin
      pc_nxt_o = pc_i + PC_INC;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC register, fetch FSM and granted-fetch counter
// Optional misaligned-target trap: PC_SEQ_MISALIGN_TRAP_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [31:0] TRAP_VEC  = DEF_TRAP_VEC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_i,
  input  logic                  br_taken_i,
  input  logic [31:0]           br_target_i,
  input  logic                  jmp_i,
  input  logic [31:0]           jmp_target_i,
  pc_sequencer_if.master        imem,
  output logic [31:0]           pc_o,
  output logic [31:0]           pc_nxt_o,
  output logic                  flush_o,
  output logic [31:0]           fetch_cnt_o,
  output logic                  misalign_o
);

  pc_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic        flush_q, misalign_q;
  logic        active, xfer, redirect, misalign;

  assign active = (state_q != BOOT);
  assign xfer   = active & imem.imem_gnt;

  pc_next_mux #(
    .TRAP_VEC (TRAP_VEC)
  ) u_next_mux (
    .active_i     (active),
    .xfer_i       (xfer),
    .stall_i      (stall_i),
    .br_taken_i   (br_taken_i),
    .br_target_i  (br_target_i),
    .jmp_i        (jmp_i),
    .jmp_target_i (jmp_target_i),
    .pc_i         (pc_q),
    .pc_nxt_o     (pc_d),
    .redirect_o   (redirect),
    .misalign_o   (misalign)
  );

  // Redirects always land in FETCH so the new target is requested immediately.
  always_comb begin
    state_d     = state_q;
    fetch_cnt_d = fetch_cnt_q + {31'd0, xfer};
    case (state_q)
      BOOT:  state_d = FETCH;
      FETCH: begin
        if (!redirect && !imem.imem_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect || imem.imem_gnt) begin
          state_d = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= BOOT;
      pc_q        <= RESET_VEC;
      fetch_cnt_q <= 32'd0;
      flush_q     <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      fetch_cnt_q <= fetch_cnt_d;
      flush_q     <= redirect;
      misalign_q  <= misalign;
    end
  end

  assign imem.imem_req  = active;
  assign imem.imem_addr = pc_q;
  assign pc_o           = pc_q;
  assign pc_nxt_o       = pc_d;
  assign flush_o        = flush_q;
  assign fetch_cnt_o    = fetch_cnt_q;
  assign misalign_o     = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer against a behavioural PC model
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        br = 1'b0;
  logic        jmp = 1'b0;
  logic [31:0] bt = '0;
  logic [31:0] jt = '0;
  logic [31:0] pc, pc_nxt, cnt;
  logic        flush, mis;

  pc_sequencer_if bus ();

  pc_sequencer #(
    .RESET_VEC (RV),
    .TRAP_VEC  (TV)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_i      (stall),
    .br_taken_i   (br),
    .br_target_i  (bt),
    .jmp_i        (jmp),
    .jmp_target_i (jt),
    .imem         (bus.master),
    .pc_o         (pc),
    .pc_nxt_o     (pc_nxt),
    .flush_o      (flush),
    .fetch_cnt_o  (cnt),
    .misalign_o   (mis)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: "booted" means the one idle cycle after reset is over and fetching has begun.
  bit          m_booted;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  bit          m_flush;
  bit          m_mis;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
  localparam bit TRAP_ON = 1'b1;
`else
  localparam bit TRAP_ON = 1'b0;
`endif

  task automatic model_reset();
    m_booted = 0; m_pc = RV; m_cnt = 0; m_flush = 0; m_mis = 0;
  endtask

  task automatic model_eval(output logic [31:0] nxt, output bit mis_o, output bit redir, output bit xfer);
    logic [31:0] tgt;
    xfer  = m_booted && (bus.imem_gnt === 1'b1);
    redir = m_booted && (jmp || br);
    mis_o = 0;
    tgt   = jmp ? jt : br ? bt : 32'd0;
    if (redir) begin
      if (TRAP_ON && (tgt % 4) != 0) begin
        nxt = TV; mis_o = 1;
      end else begin
        nxt = tgt;
      end
    end else if (stall || !xfer) begin
      nxt = m_pc;
    end else begin
      nxt = m_pc + 32'd4;
    end
  endtask

  task automatic tick();
    logic [31:0] nxt;
    bit mi, rd, xf;
    model_eval(nxt, mi, rd, xf);
    @(posedge clk);
    #1;
    if (rst_n) begin
      m_pc = nxt; m_cnt = m_cnt + (xf ? 32'd1 : 32'd0);
      m_flush = rd; m_mis = mi; m_booted = 1;
    end
  endtask

  task automatic test_reset();
    rst_n = 0; bus.imem_gnt = 0; stall = 0; br = 0; jmp = 0;
    #3;
    model_reset();
    checks++; if (pc !== RV) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc, RV); end
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", bus.imem_req); end
    checks++; if (flush !== 1'b0 || mis !== 1'b0) begin errors++; $display("FAIL reset_pulses got=%b%b exp=00", flush, mis); end
    checks++; if (cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
    @(posedge clk); #1; rst_n = 1; #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL boot_req got=%b exp=0", bus.imem_req); end
    tick();
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== RV) begin
      errors++; $display("FAIL first_req got=%b/%h exp=1/%h", bus.imem_req, bus.imem_addr, RV);
    end
  endtask

  task automatic test_sequential();
    bus.imem_gnt = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (bus.imem_addr !== 32'(i * 4)) begin
        errors++; $display("FAIL seq_addr%0d got=%h exp=%h", i, bus.imem_addr, 32'(i * 4));
      end
      tick();
    end
    checks++; if (cnt !== 32'd4) begin errors++; $display("FAIL seq_cnt got=%0d exp=4", cnt); end
  endtask

  task automatic test_wait();
    bus.imem_gnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.imem_addr !== 32'h10 || bus.imem_req !== 1'b1) begin
        errors++; $display("FAIL wait_hold%0d got=%h exp=00000010", i, bus.imem_addr);
      end
    end
    bus.imem_gnt = 1;
    tick();
    bus.imem_gnt = 0;
    checks++; if (bus.imem_addr !== 32'h14) begin errors++; $display("FAIL wait_adv got=%h exp=00000014", bus.imem_addr); end
    checks++; if (cnt !== 32'd5) begin errors++; $display("FAIL wait_cnt got=%0d exp=5", cnt); end
  endtask

  task automatic test_priority();
    br = 1; bt = 32'h200; jmp = 1; jt = 32'h300; bus.imem_gnt = 1'($urandom);
    #1;
    checks++; if (pc_nxt !== 32'h300) begin errors++; $display("FAIL prio_nxt got=%h exp=00000300", pc_nxt); end
    tick();
    br = 0; jmp = 0;
    checks++; if (bus.imem_addr !== 32'h300 || flush !== 1'b1) begin
      errors++; $display("FAIL prio_redir got=%h/%b exp=00000300/1", bus.imem_addr, flush);
    end
    tick();
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL prio_flush_once got=%b exp=0", flush); end
  endtask

  task automatic test_stall();
    int grants;
    logic [31:0] c0;
    stall = 1; bus.imem_gnt = 1; br = 1; bt = 32'h80;
    tick();
    br = 0;
    checks++; if (pc !== 32'h80 || flush !== 1'b1) begin errors++; $display("FAIL stall_br got=%h/%b exp=00000080/1", pc, flush); end
    c0 = cnt; grants = 0;
    for (int i = 0; i < 6; i++) begin
      bus.imem_gnt = 1'($urandom);
      if (bus.imem_gnt) grants++;
      tick();
      checks++; if (pc !== 32'h80) begin errors++; $display("FAIL stall_hold%0d got=%h exp=00000080", i, pc); end
    end
    checks++; if (cnt !== c0 + 32'(grants)) begin errors++; $display("FAIL stall_cnt got=%0d exp=%0d", cnt, c0 + 32'(grants)); end
    stall = 0; bus.imem_gnt = 0;
  endtask

  task automatic test_misalign();
    logic [31:0] exp_pc;
    exp_pc = TRAP_ON ? 32'h100 : 32'h102;
    jmp = 1; jt = 32'h102; bus.imem_gnt = 1'($urandom);
    tick();
    jmp = 0;
    checks++; if (pc !== exp_pc) begin errors++; $display("FAIL mis_pc got=%h exp=%h", pc, exp_pc); end
    checks++; if (mis !== TRAP_ON || flush !== 1'b1) begin errors++; $display("FAIL mis_pulse got=%b/%b exp=%b/1", mis, flush, TRAP_ON); end
    tick();
    checks++; if (mis !== 1'b0) begin errors++; $display("FAIL mis_once got=%b exp=0", mis); end
  endtask

  task automatic test_wrap();
    jmp = 1; jt = 32'hFFFF_FFFC; bus.imem_gnt = 0;
    tick();
    jmp = 0; bus.imem_gnt = 1;
    tick();
    bus.imem_gnt = 0;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc got=%h exp=00000000", pc); end
  endtask

  task automatic test_random();
    logic [31:0] nxt;
    bit mi, rd, xf;
    for (int i = 0; i < 300; i++) begin
      stall = ($urandom % 4) == 0;
      br    = ($urandom % 5) == 0;
      jmp   = ($urandom % 7) == 0;
      bt    = $urandom & ((($urandom % 6) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      jt    = $urandom & ((($urandom % 6) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      bus.imem_gnt = ($urandom % 3) != 0;
      #1;
      model_eval(nxt, mi, rd, xf);
      checks++; if (pc_nxt !== nxt) begin errors++; $display("FAIL rnd_nxt%0d got=%h exp=%h", i, pc_nxt, nxt); end
      tick();
      checks++; if (pc !== m_pc || bus.imem_addr !== m_pc || bus.imem_req !== 1'b1) begin
        errors++; $display("FAIL rnd_pc%0d got=%h/%h/%b exp=%h", i, pc, bus.imem_addr, bus.imem_req, m_pc);
      end
      checks++; if (flush !== m_flush || mis !== m_mis || cnt !== m_cnt) begin
        errors++; $display("FAIL rnd_regs%0d got=%b/%b/%0d exp=%b/%b/%0d", i, flush, mis, cnt, m_flush, m_mis, m_cnt);
      end
    end
    stall = 0; br = 0; jmp = 0; bus.imem_gnt = 0;
  endtask

  task automatic test_reset_in_wait();
    jmp = 1; jt = 32'h40;
    tick();
    jmp = 0; bus.imem_gnt = 0;
    tick();
    checks++; if (bus.imem_addr !== 32'h40) begin errors++; $display("FAIL rw_addr got=%h exp=00000040", bus.imem_addr); end
    #2; rst_n = 0; #1;
    model_reset();
    checks++; if (pc !== RV || bus.imem_req !== 1'b0 || cnt !== 32'd0 || flush !== 1'b0 || mis !== 1'b0) begin
      errors++; $display("FAIL rw_clear got=%h/%b/%0d/%b/%b exp=%h/0/0/0/0", pc, bus.imem_req, cnt, flush, mis, RV);
    end
    @(posedge clk); #1; rst_n = 1; #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rw_boot got=%b exp=0", bus.imem_req); end
    tick();
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== RV) begin
      errors++; $display("FAIL rw_req got=%b/%h exp=1/%h", bus.imem_req, bus.imem_addr, RV);
    end
  endtask

  initial begin
    bus.imem_gnt = 1'b0;
    test_reset();
    test_sequential();
    test_wait();
    test_priority();
    test_stall();
    test_misalign();
    test_wrap();
    test_random();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
